// File: rtl/dm_read_arbiter.sv
// Two-requester arbiter for the data-memory read bus with a tag FIFO that routes in-order responses back.
// Optional macro DM_ARB_FIXED_PRIO_EN: req0 always wins ties (no round-robin pointer).
module dm_read_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_req0_arvalid,
  output logic            o_req0_arready,
  input  logic [XLEN-1:0] i_req0_araddr,
  output logic            o_req0_rvalid,
  input  logic            i_req0_rready,
  output logic [XLEN-1:0] o_req0_rdata,
  input  logic            i_req1_arvalid,
  output logic            o_req1_arready,
  input  logic [XLEN-1:0] i_req1_araddr,
  output logic            o_req1_rvalid,
  input  logic            i_req1_rready,
  output logic [XLEN-1:0] o_req1_rdata,
  output logic            o_dm_bus_arvalid,
  input  logic            i_dm_bus_arready,
  output logic [XLEN-1:0] o_dm_bus_araddr,
  input  logic            i_dm_bus_rvalid,
  output logic            o_dm_bus_rready,
  input  logic [XLEN-1:0] i_dm_bus_rdata,
  output logic            o_err_unexpected,
  output logic            dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // valid never waits on ready, and payload is stable while valid is high and unaccepted.

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {AR_IDLE = 1'b0, AR_ISSUE = 1'b1} ar_state_t;

  ar_state_t        state, state_next;
  logic             tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             winner, accept, push, pop, empty, head;

`ifndef DM_ARB_FIXED_PRIO_EN
  logic last_grant;  // 1 = req1 was granted most recently
`endif

  always_comb begin
    winner = 1'b0;
    if (i_req0_arvalid && i_req1_arvalid) begin
`ifdef DM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant;
`endif
    end else if (i_req1_arvalid) begin
      winner = 1'b1;
    end
  end

  // count is the registered occupancy, so a same-cycle pop cannot open a slot for an accept.
  assign accept = (state == AR_IDLE) && (i_req0_arvalid || i_req1_arvalid) && (count < MAX_CNT);
  assign push   = accept;
  assign empty  = (count == '0);
  assign head   = tag_mem[rd_ptr];

  assign o_req0_arready = accept && !winner;
  assign o_req1_arready = accept && winner;

  assign o_req0_rvalid   = i_dm_bus_rvalid && !empty && !head;
  assign o_req1_rvalid   = i_dm_bus_rvalid && !empty && head;
  assign o_dm_bus_rready = !empty && (head ? i_req1_rready : i_req0_rready);
  assign o_req0_rdata    = i_dm_bus_rdata;
  assign o_req1_rdata    = i_dm_bus_rdata;
  assign pop             = i_dm_bus_rvalid && o_dm_bus_rready;

  assign o_dm_bus_arvalid = (state == AR_ISSUE);
  assign dbg_state        = state;

  always_comb begin
    state_next = state;
    case (state)
      AR_IDLE:  if (accept) state_next = AR_ISSUE;
      AR_ISSUE: if (i_dm_bus_arready) state_next = AR_IDLE;
      default:  state_next = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= AR_IDLE;
      o_dm_bus_araddr <= '0;
    end else begin
      state <= state_next;
      if (accept) o_dm_bus_araddr <= winner ? i_req1_araddr : i_req0_araddr;
    end
  end

`ifndef DM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_grant <= 1'b1;
    else if (accept) last_grant <= winner;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A response with nothing outstanding (including stale ones after reset) is flagged until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) o_err_unexpected <= 1'b0;
    else if (i_dm_bus_rvalid && empty) o_err_unexpected <= 1'b1;
  end

endmodule
